// File: rtl/rr_psel_gen.sv
// Multi-grant round-robin priority selector: grants up to REQS requesters per cycle,
// scanning from a registered rotating pointer that advances only on ack.
module rr_psel_gen #(
   parameter int WIDTH = 16,
   parameter int REQS  = 2,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [WIDTH-1:0]       req,
   input  logic                   rr_en,
   input  logic                   ack,
   output logic [WIDTH-1:0]       gnt,
   output logic [WIDTH*REQS-1:0]  gnt_bus,
   output logic [IDXW*REQS-1:0]   gnt_idx,
   output logic [REQS-1:0]        gnt_valid,
   output logic                   empty,
   output logic [IDXW-1:0]        ptr
);

   localparam int CW = $clog2(2*WIDTH + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   logic [IDXW-1:0]    start;
   logic [WIDTH-1:0]   hi_mask;
   logic [2*WIDTH-1:0] dbl;
   logic [WIDTH-1:0]   slot_oh [REQS];
   logic [IDXW-1:0]    last_idx;

   // Lower copy holds bits at/after the start, upper copy holds the wrapped bits
   // below it, so the doubled vector lists requests in search order with no repeats.
   always_comb begin
      start = rr_en ? ptr : '0;
      for (int i = 0; i < WIDTH; i++) begin
         hi_mask[i] = (IDXW'(i) >= start);
      end
      dbl = {req & ~hi_mask, req & hi_mask};
   end

   // Slot j takes the set bit whose count of set bits below it equals j.
   always_comb begin : prefix_select
      logic [CW-1:0] running;
      running = '0;
      for (int j = 0; j < REQS; j++) begin
         slot_oh[j] = '0;
      end
      for (int k = 0; k < 2*WIDTH; k++) begin
         if (dbl[k]) begin
            for (int j = 0; j < REQS; j++) begin
               if (running == CW'(j)) begin
                  slot_oh[j][k % WIDTH] = 1'b1;
               end
            end
            running = running + CW'(1);
         end
      end
   end

   always_comb begin : drive_outputs
      logic [IDXW-1:0] idx;
      gnt       = '0;
      gnt_bus   = '0;
      gnt_idx   = '0;
      gnt_valid = '0;
      last_idx  = '0;
      for (int j = 0; j < REQS; j++) begin
         idx = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (slot_oh[j][i]) begin
               idx = IDXW'(i);
            end
         end
         if (reset_n && (|slot_oh[j])) begin
            gnt_valid[j]                = 1'b1;
            gnt_bus[j*WIDTH +: WIDTH]   = slot_oh[j];
            gnt_idx[j*IDXW +: IDXW]     = idx;
            gnt                         = gnt | slot_oh[j];
            last_idx                    = idx;
         end
      end
   end

   assign empty = ~|req;

   // Handshake: ack high at a posedge means the consumer took this cycle's grants
   // (computed from the pre-update ptr); only then does the pointer move past the
   // last granted index. There is no backpressure on req or grants.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (rr_en && ack && gnt_valid[0]) begin
         ptr <= (last_idx == LAST_IDX) ? '0 : last_idx + IDXW'(1);
      end
   end

endmodule

// File: tb/tb_rr_psel_gen.sv
// Bench for rr_psel_gen (WIDTH=8, REQS=2): directed scenarios then random traffic,
// each cycle compared against a search-order list model of the selector.
module tb_rr_psel_gen;

   localparam int WIDTH = 8;
   localparam int REQS  = 2;
   localparam int IDXW  = 3;

   logic                  clock = 1'b0;
   logic                  reset_n = 1'b0;
   logic [WIDTH-1:0]      req = '0;
   logic                  rr_en = 1'b1;
   logic                  ack = 1'b0;
   logic [WIDTH-1:0]      gnt;
   logic [WIDTH*REQS-1:0] gnt_bus;
   logic [IDXW*REQS-1:0]  gnt_idx;
   logic [REQS-1:0]       gnt_valid;
   logic                  empty;
   logic [IDXW-1:0]       ptr;

   int n_assert = 0;
   int n_fail   = 0;
   int m_ptr    = 0;
   bit ptr_known = 1'b0;

   rr_psel_gen #(.WIDTH(WIDTH), .REQS(REQS), .IDXW(IDXW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .rr_en     (rr_en),
      .ack       (ack),
      .gnt       (gnt),
      .gnt_bus   (gnt_bus),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .empty     (empty),
      .ptr       (ptr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check outputs, then advance the model at posedge.
   task automatic step(input logic [7:0] r, input logic en, input logic a,
                       input logic rn, input string tag);
      int q[$];
      int s, pc, n;
      logic [7:0]  e_gnt;
      logic [15:0] e_bus;
      logic [5:0]  e_idx;
      logic [1:0]  e_val;
      @(negedge clock);
      req = r; rr_en = en; ack = a; reset_n = rn;
      #1;
      s = en ? m_ptr : 0;
      for (int k = 0; k < WIDTH; k++) begin
         if (r[(s + k) % WIDTH]) q.push_back((s + k) % WIDTH);
      end
      e_gnt = '0; e_bus = '0; e_idx = '0; e_val = '0;
      n = (q.size() < REQS) ? q.size() : REQS;
      if (rn) begin
         for (int j = 0; j < n; j++) begin
            e_val[j] = 1'b1;
            e_bus[j*WIDTH + q[j]] = 1'b1;
            e_idx[j*IDXW +: IDXW] = 3'(q[j]);
            e_gnt[q[j]] = 1'b1;
         end
      end
      chk({tag, ".gnt_valid"}, 64'(gnt_valid), 64'(e_val));
      chk({tag, ".gnt_idx"},   64'(gnt_idx),   64'(e_idx));
      chk({tag, ".gnt_bus"},   64'(gnt_bus),   64'(e_bus));
      chk({tag, ".gnt"},       64'(gnt),       64'(e_gnt));
      chk({tag, ".empty"},     64'(empty),     64'(r == 8'h00));
      if (ptr_known) chk({tag, ".ptr"}, 64'(ptr), 64'(m_ptr));
      pc = $countones(r);
      chk({tag, ".onehot0"}, 64'($onehot0(gnt_bus[7:0]) && $onehot0(gnt_bus[15:8])), 64'(1));
      chk({tag, ".disjoint"}, 64'(gnt_bus[7:0] & gnt_bus[15:8]), 64'(0));
      chk({tag, ".subset"}, 64'(gnt & ~r), 64'(0));
      chk({tag, ".count"}, 64'($countones(gnt)), 64'(rn ? ((pc < REQS) ? pc : REQS) : 0));
      if (!rn) begin
         m_ptr = 0;
         ptr_known = 1'b1;
      end else if (en && a && n > 0) begin
         m_ptr = (q[n-1] + 1) % WIDTH;
      end
      @(posedge clock);
   endtask

   task automatic expect_ptr(input string tag, input int v);
      #1;
      chk({tag, ".ptr_const"}, 64'(ptr), 64'(v));
   endtask

   initial begin
      // Reset with all requests and ack asserted
      step(8'hFF, 1'b1, 1'b1, 1'b0, "reset");
      expect_ptr("reset", 0);
      // Basic rotate and wrap from L=7
      step(8'b1010_0110, 1'b1, 1'b1, 1'b1, "rot1");
      expect_ptr("rot1", 3);
      step(8'b1010_0110, 1'b1, 1'b1, 1'b1, "rot2");
      expect_ptr("rot2", 0);
      // Move ptr to 6, then wrap search
      step(8'b0010_0000, 1'b1, 1'b1, 1'b1, "to6");
      expect_ptr("to6", 6);
      step(8'b0100_0001, 1'b1, 1'b1, 1'b1, "wrap");
      expect_ptr("wrap", 1);
      // Fewer requests than slots
      step(8'b0001_0000, 1'b1, 1'b1, 1'b1, "few");
      expect_ptr("few", 5);
      // Fixed mode freezes ptr despite ack
      step(8'hFF, 1'b0, 1'b1, 1'b1, "fixed");
      expect_ptr("fixed", 5);
      for (int c = 0; c < 3; c++) step(8'hFF, 1'b1, 1'b0, 1'b1, "noack");
      expect_ptr("noack", 5);
      // Empty with ack
      step(8'h00, 1'b1, 1'b1, 1'b1, "empty");
      expect_ptr("empty", 5);
      // Reset mid-stream wins over ack
      step(8'hFF, 1'b1, 1'b1, 1'b0, "midrst");
      expect_ptr("midrst", 0);
      step(8'hFF, 1'b1, 1'b0, 1'b1, "postrst");
      // Random traffic
      for (int c = 0; c < 400; c++) begin
         step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0), "rand");
      end
      step(8'h00, 1'b1, 1'b0, 1'b1, "final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_psel_gen.md
# rr_psel_gen

Parametrised multi-grant round-robin priority selector with a registered rotating priority pointer. It grants up to REQS of WIDTH requesters per cycle. The scan starts at the pointer and wraps modulo WIDTH, so no requester starves. The pointer advances only when the consumer acknowledges the grants. This block is the successor to the fixed-priority multi-grant selector used for reservation-station issue and ROB/RS entry allocation. Modes: round-robin or fixed (index 0 first).

## Interface
- WIDTH, 16, number of requesters (2..64, need not be a power of 2)
- REQS, 2, grant slots per cycle (1..WIDTH)
- IDXW, $clog2(WIDTH), index width
- clock  input  1  single clock; all state updates on posedge
- reset_n  input  1  synchronous, active-low reset
- req  input  WIDTH  request vector, bit i = requester i
- rr_en  input  1  1: scan starts at ptr; 0: fixed priority, scan starts at 0
- ack  input  1  consumer accepted this cycle's grants; enables pointer update
- gnt  output  WIDTH  OR of all slot grants
- gnt_bus  output  WIDTH*REQS  one-hot grant per slot; slot j occupies bits [(j+1)*WIDTH-1 -: WIDTH]
- gnt_idx  output  IDXW*REQS  binary index per slot; 0 when that slot is invalid
- gnt_valid  output  REQS  slot j holds a grant
- empty  output  1  ~|req
- ptr  output  IDXW  current priority pointer (registered)

## Operation
- Search order: start s = ptr when rr_en=1, or s = 0 when rr_en=0. Visit indices s, s+1, …, WIDTH-1, 0, …, s-1.
- Slot j takes the (j+1)-th asserted req bit in search order.
  - Slots fill contiguously from slot 0.
  - gnt_valid[j] = 1 iff popcount(req) > j.
  - An invalid slot drives gnt_bus = 0 and gnt_idx = 0.
- Slot grants are mutually exclusive. gnt has popcount = min(popcount(req), REQS). No bit outside req is ever granted.
- Pointer update, registered:
  - Update only when reset_n=1, rr_en=1, ack=1 and gnt_valid[0]=1.
  - Then ptr <= (L+1) mod WIDTH, where L = gnt_idx of the highest valid slot.
  - Wrap is an explicit compare against WIDTH-1, not a power-of-2 truncate.
  - Otherwise ptr holds.
- rr_en=0: grants use fixed priority from index 0. ptr is frozen, including when ack=1.
- Reset, synchronous:
  - ptr <= 0 on the edge where reset_n=0.
  - While reset_n=0, gnt, gnt_bus, gnt_idx and gnt_valid are forced to 0.
  - empty still reflects req.
- empty is independent of rr_en, ack and reset.

## Timing
- Grant path is combinational: req/rr_en/ptr to gnt* in the same cycle, with zero-cycle latency.
- ptr latency: 1 cycle after the ack edge.
- ack is sampled at posedge. Grants in the ack cycle are based on the pre-update ptr.
- ack with no valid grant: ptr unchanged.
- ack held low: ptr holds indefinitely. Grants may change with req, and there is no grant stability guarantee without ack.
- Reset asserted mid-stream (ack=1 in the same cycle): reset wins and ptr = 0 next cycle.
- REQS=1 degenerates to a single-grant round-robin arbiter. REQS=WIDTH grants every request.
- Critical path: a doubled-vector (2*WIDTH) masked priority chain per slot. The implementation must avoid a REQS×WIDTH ripple by using masked prefix selection.

## Test plan
All scenarios use WIDTH=8, REQS=2.
- Reset: reset_n=0, req=8'hFF, ack=1 → gnt=0, gnt_valid=2'b00, empty=0; ptr=0 after the edge.
- Basic rotate: ptr=0, rr_en=1, req=8'b1010_0110 → gnt_idx slot0=1, slot1=2, gnt=8'b0000_0110, gnt_valid=2'b11.
  - ack=1 → ptr=3.
  - Same req next cycle → idx 5 and 7; ack → ptr=0 (wrap from L=7).
- Wrap search: ptr=6, req=8'b0100_0001 → slot0=6, slot1=0; ack → ptr=1.
- Fewer requests than slots: ptr=1, req=8'b0001_0000 → slot0=4, gnt_valid=2'b01, slot1 bus/idx=0; ack → ptr=5.
- Mode/handshake: ptr=5, rr_en=0, req=8'hFF, ack=1 → idx 0 and 1, ptr stays 5.
  - Then rr_en=1, ack=0 for 3 cycles → idx 5 and 6 each cycle, ptr stays 5.
- Empty and reset mid-operation: req=0, ack=1 → empty=1, gnt_valid=0, ptr unchanged.
  - Then ptr=5, req=8'hFF, ack=1, reset_n=0 → ptr=0 next cycle, all grants 0 during reset.
- Bench check every cycle: slot grants are one-hot or zero, pairwise disjoint, subset of req, and count = min(popcount(req), 2).
